// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives an 8N1 program image over UART, packs bytes into
// little-endian 32-bit words and writes them to instruction memory through a
// req/gnt port. The core is held in reset until the image has loaded.
// Optional checksum word after the image: enable with `define BOOT_CHECKSUM_EN.
module uart_boot_loader #(
  parameter int unsigned       CLKS_PER_BIT = 868,
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int unsigned       MAX_WORDS    = 4096
) (
  input  logic              clk_in1,
  input  logic              rst,
  input  logic              uart_rx_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              core_rst_no
);
  localparam int unsigned   CW      = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  // ---------------------------------------------------------------- RX path
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  // Two-flop synchroniser plus one delay flop for falling-edge detection.
  always_ff @(posedge clk_in1 or negedge rst) begin
    if (!rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // RX_BRK waits for the line to return high after a framing error.
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK} rx_st_e;
  rx_st_e        rx_st_q, rx_st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          bv_q, bv_d, ferr_q, ferr_d;

  // Bit timing: start bit checked at mid-bit, then one sample per bit period.
  always_comb begin
    rx_st_d = rx_st_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    bv_d    = 1'b0;
    ferr_d  = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_st_d = RX_START;
      end
      RX_START: if (cnt_q == HALF_M1) begin
        cnt_d   = '0;
        bit_d   = '0;
        rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == FULL_M1) begin
        cnt_d = '0;
        sh_d  = {rx_s2_q, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) rx_st_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == FULL_M1) begin
        cnt_d = '0;
        if (rx_s2_q) begin
          bv_d    = 1'b1;
          rx_st_d = RX_IDLE;
        end else begin
          ferr_d  = 1'b1;
          rx_st_d = RX_BRK;
        end
      end
      RX_BRK: begin
        cnt_d = '0;
        if (rx_s2_q) rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // RX state registers; bv_q/ferr_q are single-cycle pulses.
  always_ff @(posedge clk_in1 or negedge rst) begin
    if (!rst) begin
      rx_st_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      bv_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_st_q <= rx_st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      bv_q    <= bv_d;
      ferr_q  <= ferr_d;
    end
  end

  // ------------------------------------------------------------------ loader
`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {LD_LEN, LD_DATA, LD_CSUM, LD_DONE, LD_ERR} ld_st_e;
  logic [31:0] sum_q, sum_d;
`else
  typedef enum logic [2:0] {LD_LEN, LD_DATA, LD_DONE, LD_ERR} ld_st_e;
`endif
  ld_st_e            ld_q, ld_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       wsh_q, wsh_d;
  logic [31:0]       n_q, n_d;
  logic [31:0]       gcnt_q, gcnt_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_q, done_q, err_q;
  logic              word_done, granted, last;
  logic [31:0]       word;

  // Word assembly, write issue and load sequencing. A grant and a completed
  // word in the same cycle are both honoured: the new write follows the old.
  always_comb begin
    ld_d      = ld_q;
    bcnt_d    = bcnt_q;
    wsh_d     = wsh_q;
    n_d       = n_q;
    gcnt_d    = gcnt_q;
    req_d     = req_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    last      = 1'b0;
    word      = {sh_q, wsh_q[31:8]};
    word_done = bv_q && (bcnt_q == 2'd3);
    granted   = req_q && mem_gnt_i;
    if (bv_q && ld_q != LD_DONE && ld_q != LD_ERR) begin
      bcnt_d = bcnt_q + 2'd1;
      wsh_d  = word;
    end
    unique case (ld_q)
      LD_LEN: if (word_done) begin
        if (word == 32'd0) begin
`ifdef BOOT_CHECKSUM_EN
          ld_d = LD_CSUM;
`else
          ld_d = LD_DONE;
`endif
        end else if (word > 32'(MAX_WORDS)) begin
          ld_d = LD_ERR;
        end else begin
          n_d  = word;
          ld_d = LD_DATA;
        end
      end
      LD_DATA: begin
        if (granted) begin
          req_d  = 1'b0;
          addr_d = addr_q + ADDR_W'(4);
          gcnt_d = gcnt_q + 32'd1;
          if (gcnt_q + 32'd1 == n_q) begin
            last = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            ld_d = LD_CSUM;
            // Checksum word landing on the final grant cycle.
            if (word_done) ld_d = (word == sum_q) ? LD_DONE : LD_ERR;
`else
            ld_d = LD_DONE;
`endif
          end
        end
        if (word_done && !last) begin
          if (req_q && !mem_gnt_i) begin
            ld_d = LD_ERR;            // overrun: pending write is dropped
          end else begin
            req_d   = 1'b1;
            wdata_d = word;
`ifdef BOOT_CHECKSUM_EN
            sum_d   = sum_q + word;
`endif
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      LD_CSUM: if (word_done) ld_d = (word == sum_q) ? LD_DONE : LD_ERR;
`endif
      default: ;
    endcase
    if (ferr_q && ld_q != LD_DONE) ld_d = LD_ERR;
    if (ld_d == LD_ERR) req_d = 1'b0;
  end

  // Loader registers; status outputs are registered from the next state.
  always_ff @(posedge clk_in1 or negedge rst) begin
    if (!rst) begin
      ld_q    <= LD_LEN;
      bcnt_q  <= '0;
      wsh_q   <= '0;
      n_q     <= '0;
      gcnt_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      ld_q    <= ld_d;
      bcnt_q  <= bcnt_d;
      wsh_q   <= wsh_d;
      n_q     <= n_d;
      gcnt_q  <= gcnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q   <= sum_d;
      busy_q  <= (ld_d == LD_DATA) || (ld_d == LD_CSUM);
`else
      busy_q  <= (ld_d == LD_DATA);
`endif
      done_q  <= (ld_d == LD_DONE);
      err_q   <= (ld_d == LD_ERR);
    end
  end

  assign mem_req_o   = req_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign core_rst_no = done_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: drives UART images into uart_boot_loader and compares
// the memory writes and status flags with a word-level model of a load.
module tb_uart_boot_loader;
  localparam int          CPB  = 16;
  localparam int          MAXW = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk_in1 = 1'b0, rst = 1'b0, uart_rx_i = 1'b1, mem_gnt_i = 1'b0;
  logic        mem_req_o, busy_o, done_o, err_o, core_rst_no;
  logic [31:0] mem_addr_o, mem_wdata_o;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(32), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk_in1(clk_in1), .rst(rst), .uart_rx_i(uart_rx_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .core_rst_no(core_rst_no));

  always #5 clk_in1 = ~clk_in1;

  int          vecs = 0, miscmp = 0;
  int          gnt_mode = 0;          // 0: gnt tied high, 1: 40-cycle delay, 2: withheld
  int          waitc = 0;
  logic        pend = 1'b0;
  logic [31:0] pa = '0, pd = '0;
  logic [31:0] wr_addr[$], wr_data[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Grant driver and write monitor, both on the falling edge.
  initial begin
    forever begin
      @(negedge clk_in1);
      if (pend && !err_o && rst) begin
        chk("hold_req", 32'(mem_req_o), 32'd1);
        chk("hold_addr", mem_addr_o, pa);
        chk("hold_data", mem_wdata_o, pd);
      end
      case (gnt_mode)
        0:       mem_gnt_i = 1'b1;
        1:       mem_gnt_i = mem_req_o && (waitc >= 40);
        default: mem_gnt_i = 1'b0;
      endcase
      if (mem_req_o && !mem_gnt_i) waitc++; else waitc = 0;
      if (mem_req_o && mem_gnt_i && rst) begin
        wr_addr.push_back(mem_addr_o);
        wr_data.push_back(mem_wdata_o);
      end
      pend = mem_req_o && !mem_gnt_i;
      pa   = mem_addr_o;
      pd   = mem_wdata_o;
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    uart_rx_i = 1'b0;
    repeat (CPB) @(negedge clk_in1);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (CPB) @(negedge clk_in1);
    end
    uart_rx_i = !bad_stop;
    repeat (CPB) @(negedge clk_in1);
    uart_rx_i = 1'b1;
    repeat ($urandom_range(1, CPB)) @(negedge clk_in1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},  32'(mem_req_o), 32'd0);
    chk({tag, "_addr"}, mem_addr_o, BASE);
    chk({tag, "_data"}, mem_wdata_o, 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_err"},  32'(err_o), 32'd0);
    chk({tag, "_crst"}, 32'(core_rst_no), 32'd0);
  endtask

  task automatic do_reset(input bit check);
    rst = 1'b0;
    repeat (3) @(negedge clk_in1);
    if (check) chk_reset_vals("rst_in");
    rst = 1'b1;
    repeat (2) @(negedge clk_in1);
    if (check) chk_reset_vals("rst_out");
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Model of a load: a header within range writes every word at BASE+4k;
  // the load succeeds when the header is in range and the checksum agrees.
  task automatic run_load(input string tag, input logic [31:0] hdr,
                          input logic [31:0] wl[$], input bit csum_bad, input int mode);
    logic [31:0] sum = 0;
    bit          ok;
    int          nexp;
    gnt_mode = mode;
    wr_addr.delete();
    wr_data.delete();
    send_word(hdr);
    foreach (wl[i]) begin
      send_word(wl[i]);
      sum += wl[i];
    end
`ifdef BOOT_CHECKSUM_EN
    if (hdr <= MAXW) send_word(csum_bad ? sum + 32'd1 : sum);
`endif
    repeat (4 * CPB) @(negedge clk_in1);
    ok   = (hdr <= MAXW) && !csum_bad;
    nexp = (hdr <= MAXW) ? int'(hdr) : 0;
    chk({tag, "_wr_count"}, 32'(wr_addr.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < wr_addr.size(); i++) begin
      chk({tag, "_wr_addr"}, wr_addr[i], BASE + 32'(4 * i));
      chk({tag, "_wr_data"}, wr_data[i], wl[i]);
    end
    chk({tag, "_done"}, 32'(done_o), 32'(ok));
    chk({tag, "_err"},  32'(err_o), 32'(!ok));
    chk({tag, "_crst"}, 32'(core_rst_no), 32'(ok));
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    // Anything after completion or error must not produce writes.
    send_word($urandom);
    repeat (2 * CPB) @(negedge clk_in1);
    chk({tag, "_post_wr"}, 32'(wr_addr.size()), 32'(nexp));
    chk({tag, "_post_done"}, 32'(done_o), 32'(ok));
  endtask

  initial begin
    logic [31:0] wl[$];
    int          n;
    repeat (3) @(negedge clk_in1);
    chk_reset_vals("por");
    rst = 1'b1;
    repeat (2) @(negedge clk_in1);

    // Basic two-word load, grant always high.
    wl = '{32'hDEAD_BEEF, 32'h0000_0013};
    run_load("basic", 32'd2, wl, 1'b0, 0);

    // Same image with a 40-cycle grant delay.
    do_reset(1'b0);
    run_load("slow_gnt", 32'd2, wl, 1'b0, 1);

    // Overrun: grant withheld until a second word completes.
    do_reset(1'b0);
    gnt_mode = 2;
    send_word(32'd3);
    send_word($urandom);
    send_word($urandom);
    repeat (2 * CPB) @(negedge clk_in1);
    chk("ovr_err", 32'(err_o), 32'd1);
    chk("ovr_crst", 32'(core_rst_no), 32'd0);
    chk("ovr_req", 32'(mem_req_o), 32'd0);
    gnt_mode = 0;
    send_word($urandom);
    repeat (2 * CPB) @(negedge clk_in1);
    chk("ovr_wr_count", 32'(wr_addr.size()), 32'd0);
    chk("ovr_err_hold", 32'(err_o), 32'd1);

    // Framing error.
    do_reset(1'b0);
    send_byte(8'h55, 1'b1);
    repeat (2 * CPB) @(negedge clk_in1);
    chk("ferr_err", 32'(err_o), 32'd1);
    chk("ferr_done", 32'(done_o), 32'd0);

    // Short low glitch then a valid image.
    do_reset(1'b0);
    uart_rx_i = 1'b0;
    repeat (3) @(negedge clk_in1);
    uart_rx_i = 1'b1;
    repeat (3 * CPB) @(negedge clk_in1);
    chk("glitch_err", 32'(err_o), 32'd0);
    wl = '{$urandom, $urandom};
    run_load("glitch", 32'd2, wl, 1'b0, 0);

    // Oversize header.
    do_reset(1'b0);
    wl = '{$urandom, $urandom};
    run_load("oversize", 32'(MAXW + 1), wl, 1'b0, 0);

`ifdef BOOT_CHECKSUM_EN
    do_reset(1'b0);
    wl = '{32'd1, 32'd2};
    run_load("csum_ok", 32'd2, wl, 1'b0, 0);
    do_reset(1'b0);
    run_load("csum_bad", 32'd2, wl, 1'b1, 0);
`endif

    // Reset in the middle of the data phase, then a fresh load.
    do_reset(1'b0);
    gnt_mode = 0;
    send_word(32'd3);
    send_word($urandom);
    send_byte(8'hA5, 1'b0);
    chk("mid_busy", 32'(busy_o), 32'd1);
    do_reset(1'b1);
    wl = '{$urandom, $urandom, $urandom};
    run_load("after_rst", 32'd3, wl, 1'b0, 0);

    // Boundaries: empty image and the largest accepted image.
    do_reset(1'b0);
    wl = {};
    run_load("n_zero", 32'd0, wl, 1'b0, 0);
    do_reset(1'b0);
    wl = {};
    for (int i = 0; i < MAXW; i++) wl.push_back($urandom);
    run_load("n_max", 32'(MAXW), wl, 1'b0, 0);

    // Random images with random grant behaviour.
    for (int r = 0; r < 2; r++) begin
      do_reset(1'b0);
      n  = $urandom_range(1, MAXW);
      wl = {};
      for (int i = 0; i < n; i++) wl.push_back($urandom);
      run_load("rand", 32'(n), wl, 1'b0, $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
